// File: rtl/pcie_vc_dispatcher.sv
// pcie_vc_dispatcher: encodes the arbiter's one-hot VC grant, runs a fixed-length
// link burst for it, pulses a per-VC done and keeps saturating per-VC burst counts.
module pcie_vc_dispatcher #(
   parameter int BURST_LEN = 4,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [7:0]       id,
   input  logic             link_ready,
   output logic             link_valid,
   output logic [2:0]       link_vc,
   output logic [3:0]       link_beat,
   output logic             busy,
   output logic [7:0]       done,
   output logic             err,
   input  logic [2:0]       cnt_sel,
   output logic [CNT_W-1:0] cnt_out
);
   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
   state_t           r_state, w_next;
   logic [2:0]       r_vc, w_enc;
   logic [3:0]       r_beat;
   logic             r_err;
   logic [CNT_W-1:0] r_cnt [8];
   logic             w_onehot, w_multi, w_hs, w_last;
   always_comb begin
      w_enc = '0;
      for (int i = 0; i < 8; i++) if (id[i]) w_enc = 3'(i);
   end
   // id & (id-1) clears the lowest set bit; nonzero leftovers mean more than one grant
   assign w_multi  = (id & (id - 8'd1)) != 8'd0;
   assign w_onehot = (id != 8'd0) && !w_multi;
   assign w_hs     = (r_state == XFER) && link_ready;
   assign w_last   = r_beat == 4'(BURST_LEN - 1);
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_onehot ? XFER : IDLE;
         XFER:    w_next = (w_hs && w_last) ? DONE : XFER;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge clr)
      if (!clr) r_state <= IDLE;
      else      r_state <= w_next;
   always_ff @(posedge clk or negedge clr)
      if (!clr) begin
         r_vc   <= '0;
         r_beat <= '0;
         r_err  <= 1'b0;
         for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
      end else begin
         if (r_state == IDLE && w_onehot) r_vc <= w_enc;
         if (r_state == IDLE && w_multi) r_err <= 1'b1;
         if (w_hs) r_beat <= w_last ? 4'd0 : r_beat + 4'd1;
         if (r_state == DONE && r_cnt[r_vc] != '1) r_cnt[r_vc] <= r_cnt[r_vc] + CNT_W'(1);
      end
   assign link_valid = r_state == XFER;
   assign link_vc    = r_vc;
   assign link_beat  = r_beat;
   assign busy       = r_state != IDLE;
   assign done       = (r_state == DONE) ? (8'd1 << r_vc) : 8'd0;
   assign err        = r_err;
   assign cnt_out    = r_cnt[cnt_sel];
endmodule

// File: tb/tb_pcie_vc_dispatcher.sv
// tb_pcie_vc_dispatcher: randomized grants/backpressure with a queue scoreboard
// and a per-VC burst-count model derived from the grant sequence.
module tb_pcie_vc_dispatcher;
   localparam int L = 4;
   logic       clk = 1'b0, clr = 1'b0, link_ready = 1'b0;
   logic [7:0] id = 8'd0;
   logic [2:0] cnt_sel = 3'd0;
   logic       link_valid, busy, err;
   logic [2:0] link_vc;
   logic [3:0] link_beat;
   logic [7:0] done;
   logic [7:0] cnt_out;
   always #5 clk = ~clk;
   pcie_vc_dispatcher #(.BURST_LEN(L), .CNT_W(8)) dut (
      .clk(clk), .clr(clr), .id(id), .link_ready(link_ready),
      .link_valid(link_valid), .link_vc(link_vc), .link_beat(link_beat),
      .busy(busy), .done(done), .err(err), .cnt_sel(cnt_sel), .cnt_out(cnt_out)
   );
   typedef struct packed {logic [2:0] vc; logic [3:0] beat;} beat_t;
   int         n_tests = 0, n_fail = 0;
   beat_t      q_beat[$];
   logic [7:0] q_done[$];
   int         m_cnt[8];
   logic       m_err = 1'b0;
   logic       prev_stall = 1'b0;
   logic [6:0] prev_pos;
   beat_t      e_beat;
   logic [7:0] e_done;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // monitor: pops the scoreboard whenever the DUT presents a beat or a done pulse
   always @(negedge clk) begin
      if (clr) begin
         if (prev_stall) begin
            check("stall_valid", link_valid, 1);
            check("stall_hold", {link_vc, link_beat}, prev_pos);
         end
         if (link_valid && link_ready) begin
            if (q_beat.size() == 0) check("beat_unexpected", {link_vc, link_beat}, 32'hffff);
            else begin
               e_beat = q_beat.pop_front();
               check("beat", {link_vc, link_beat}, e_beat);
            end
         end
         if (done != 8'd0) begin
            if (q_done.size() == 0) check("done_unexpected", done, 0);
            else begin
               e_done = q_done.pop_front();
               check("done", done, e_done);
            end
         end
         check("err", err, m_err);
      end
      prev_stall = clr && link_valid && !link_ready;
      prev_pos   = {link_vc, link_beat};
   end
   task automatic wait_idle();
      for (int k = 0; k < 100 && busy; k++) begin @(posedge clk); #1; end
      if (busy) check("idle_timeout", busy, 0);
   endtask
   // mode 0: ready high, 1: random ready, 2: ready low for 3 cycles at beat 1
   task automatic issue(input logic [7:0] g, input int mode, input logic [7:0] chain);
      int cyc, st;
      logic [2:0] v;
      wait_idle();
      id = g;
      if ($countones(g) == 1) begin
         v = 3'd0;
         for (int i = 0; i < 8; i++) if (g[i]) v = 3'(i);
         for (int b = 0; b < L; b++) q_beat.push_back({v, 4'(b)});
         q_done.push_back(g);
         m_cnt[v] = (m_cnt[v] == 255) ? 255 : m_cnt[v] + 1;
         @(posedge clk); #1;
         check("first_valid", link_valid, 1);
         check("first_vc", link_vc, v);
         check("first_beat", link_beat, 0);
         check("busy", busy, 1);
         cyc = 0;
         st = 0;
         for (int k = 0; k < 500; k++) begin
            if (mode == 0) link_ready = 1'b1;
            else if (mode == 1) link_ready = 1'($urandom_range(0, 1));
            else if (link_beat == 4'd1 && st < 3) begin link_ready = 1'b0; st++; end
            else link_ready = 1'b1;
            id = 8'($urandom);
            @(posedge clk); #1;
            cyc++;
            if (done != 8'd0) break;
         end
         check("done_seen", done != 8'd0, 1);
         id = chain;
         link_ready = 1'($urandom_range(0, 1));
         if (mode != 1) check("burst_cycles", cyc, (mode == 2) ? L + 3 : L);
         check("busy_in_done", busy, 1);
         @(posedge clk); #1;
         check("busy_after", busy, 0);
         check("valid_after", link_valid, 0);
         cnt_sel = v;
         #1;
         check("cnt", cnt_out, m_cnt[v]);
      end else begin
         @(posedge clk); #1;
         if (g != 8'd0) m_err = 1'b1;
         check("no_burst_busy", busy, 0);
         check("no_burst_valid", link_valid, 0);
         check("err_now", err, m_err);
         id = chain;
      end
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      int r;
      logic [7:0] g;
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      #1;
      check("rst_valid", link_valid, 0);
      check("rst_vc", link_vc, 0);
      check("rst_beat", link_beat, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_cnt", cnt_out, 0);
      @(posedge clk); #1;
      clr = 1'b1;
      link_ready = 1'b1;
      issue(8'b0000_0100, 0, 8'd0);
      issue(8'b1000_0000, 2, 8'd0);
      issue(8'b0000_0110, 0, 8'd0);
      issue(8'b0000_0000, 0, 8'd0);
      issue(8'b0000_1000, 0, 8'd0);
      issue(8'b0000_0010, 1, 8'b0100_0000);
      issue(8'b0100_0000, 0, 8'd0);
      repeat (40) begin
         r = int'($urandom_range(0, 9));
         g = (r < 7) ? 8'(1 << $urandom_range(0, 7)) : (r < 8) ? 8'd0 : 8'($urandom);
         issue(g, int'($urandom_range(0, 2)), 8'd0);
      end
      wait_idle();
      id = 8'b0000_0001;
      link_ready = 1'b1;
      for (int b = 0; b < L; b++) q_beat.push_back({3'd0, 4'(b)});
      q_done.push_back(8'b0000_0001);
      @(posedge clk); #1;
      id = 8'd0;
      for (int k = 0; k < 20 && link_beat != 4'd2; k++) begin @(posedge clk); #1; end
      check("reach_beat2", link_beat, 2);
      clr = 1'b0;
      #1;
      check("arst_valid", link_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_err", err, 0);
      check("arst_beat", link_beat, 0);
      check("arst_vc", link_vc, 0);
      q_beat.delete();
      q_done.delete();
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      m_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      clr = 1'b1;
      cnt_sel = 3'd0;
      #1;
      check("cnt_vc0_after_rst", cnt_out, 0);
      repeat (256) issue(8'b0010_0000, 0, 8'd0);
      for (int i = 0; i < 8; i++) begin
         cnt_sel = 3'(i);
         #1;
         check("cnt_sweep", cnt_out, m_cnt[i]);
      end
      repeat (3) @(posedge clk);
      #1;
      check("beats_drained", q_beat.size(), 0);
      check("dones_drained", q_done.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
